// File: rtl/op_pkg.sv
// ---------------------------------------------------------------------------
// op_pkg
// Shared definitions for the opcode arbiter: the opcode values understood by
// the downstream decoder, the arbiter FSM state type and a legality check.
// No ports (package).
// ---------------------------------------------------------------------------
package op_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] WRITE_A = 4'b0001;
  localparam logic [3:0] WRITE_B = 4'b0010;
  localparam logic [3:0] READ_C  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  // Only these three opcodes are forwarded to the decoder; everything else
  // is consumed and counted as illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == WRITE_A) || (op == WRITE_B) || (op == READ_C);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection. Scans req_valid starting
// at rr_ptr and wrapping at NUM_REQ; the first valid requester wins.
// Ports:
//   req_valid   in   NUM_REQ          request valid per requester
//   rr_ptr      in   clog2(NUM_REQ)   highest-priority requester index
//   grant       out  NUM_REQ          one-hot grant (all zero if none valid)
//   grant_idx   out  clog2(NUM_REQ)   index of the granted requester
//   grant_valid out  1                some requester is valid
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Candidate index is rr_ptr+k reduced modulo NUM_REQ with one conditional
  // subtract, which also covers NUM_REQ values that are not powers of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      cand = sum[IW-1:0];
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/op_arbiter.sv
// ---------------------------------------------------------------------------
// op_arbiter
// Shares the decoder's single opcode port between NUM_REQ requesters with
// round-robin arbitration. Legal opcodes are issued as one-cycle op_valid
// pulses, READ_C keeps the port busy for READ_LAT further cycles, illegal
// opcodes are consumed, flagged and counted in a saturating counter.
// Ports:
//   clk        in   1                clock, rising edge
//   rst_n      in   1                synchronous active-low reset
//   req_valid  in   NUM_REQ          per-requester request valid
//   req_op     in   4*NUM_REQ        requester i opcode in [4i+3:4i]
//   req_ready  out  NUM_REQ          combinational accept, at most one hot
//   op_code    out  4                issued opcode, 0 when op_valid=0
//   op_valid   out  1                one-cycle issue strobe
//   op_id      out  clog2(NUM_REQ)   requester of current op_valid/illegal
//   illegal    out  1                one-cycle illegal-op pulse
//   busy       out  1                combinational, high while not accepting
//   err_cnt    out  ERR_W            saturating illegal-op count
// ---------------------------------------------------------------------------
module op_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int READ_LAT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_op,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [3:0]                 op_code,
  output logic                       op_valid,
  output logic [$clog2(NUM_REQ)-1:0] op_id,
  output logic                       illegal,
  output logic                       busy,
  output logic [ERR_W-1:0]           err_cnt
);

  import op_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [IW-1:0] rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic [3:0]         sel_op;
  logic               read_issued;
  logic               accept_en;
  logic               xfer;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // The registered op_code tells us what was issued this cycle, so no extra
  // "last op was a read" flag is needed. Acceptance closes during the READ_C
  // issue cycle and all HOLD cycles except the last one.
  always_comb begin
    read_issued = (state == ISSUE) && op_valid && (op_code == READ_C);
    accept_en   = 1'b1;
    if ((READ_LAT > 0) && read_issued) begin
      accept_en = 1'b0;
    end
    if ((state == HOLD) && (hold_cnt > HW'(1))) begin
      accept_en = 1'b0;
    end
    sel_op    = req_op[{grant_idx, 2'b00} +: 4];
    xfer      = grant_valid && accept_en;
    req_ready = accept_en ? grant : '0;
    busy      = ~accept_en;
  end

  // Next-state logic. A transfer always leads to ISSUE; a READ_C issue with
  // nonzero latency enters HOLD with the full count; HOLD counts down and
  // drops to IDLE once its final cycle passes without a transfer.
  always_comb begin
    state_nxt = IDLE;
    hold_nxt  = '0;
    if (xfer) begin
      state_nxt = ISSUE;
    end else if ((READ_LAT > 0) && read_issued) begin
      state_nxt = HOLD;
      hold_nxt  = HW'(READ_LAT);
    end else if ((state == HOLD) && (hold_cnt > HW'(1))) begin
      state_nxt = HOLD;
      hold_nxt  = hold_cnt - HW'(1);
    end
  end

  // State, hold counter and round-robin pointer. The pointer only moves on a
  // real transfer, to the requester just after the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (xfer) begin
        rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      end
    end
  end

  // Registered issue outputs: strobes are cleared every cycle and only raised
  // for the transfer accepted at this edge. op_id holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_code  <= OP_NOP;
      op_valid <= 1'b0;
      op_id    <= '0;
      illegal  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      op_code  <= OP_NOP;
      op_valid <= 1'b0;
      illegal  <= 1'b0;
      if (xfer) begin
        op_id <= grant_idx;
        if (is_legal_op(sel_op)) begin
          op_valid <= 1'b1;
          op_code  <= sel_op;
        end else begin
          illegal <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_op_arbiter
// Self-checking bench for op_arbiter (NUM_REQ=4, READ_LAT=2). A second
// instance with ERR_W=2 shares all inputs so counter saturation is visible
// on the same stimulus. Per-cycle vectors carry hand-derived expectations;
// registered expectations go through a scoreboard queue and are compared
// after the clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_op_arbiter;

  import op_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_op;

  logic [3:0]  req_ready;
  logic [3:0]  op_code;
  logic        op_valid;
  logic [1:0]  op_id;
  logic        illegal;
  logic        busy;
  logic [7:0]  err_cnt;

  logic [3:0]  s_ready;
  logic [3:0]  s_code;
  logic        s_valid;
  logic [1:0]  s_id;
  logic        s_illegal;
  logic        s_busy;
  logic [1:0]  s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  op_arbiter #(.NUM_REQ(4), .READ_LAT(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .op_code(op_code), .op_valid(op_valid),
    .op_id(op_id), .illegal(illegal), .busy(busy), .err_cnt(err_cnt)
  );

  op_arbiter #(.NUM_REQ(4), .READ_LAT(2), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_ready(s_ready), .op_code(s_code), .op_valid(s_valid),
    .op_id(s_id), .illegal(s_illegal), .busy(s_busy), .err_cnt(s_err)
  );

  typedef struct {
    logic        rstn;
    logic [3:0]  valid;
    logic [15:0] ops;
    logic [3:0]  ready;
    logic        bsy;
    logic        ov;
    logic [3:0]  code;
    logic [1:0]  id;
    logic        ill;
    logic [7:0]  err;
    logic [1:0]  err2;
  } vec_t;

  typedef struct {
    logic       ov;
    logic [3:0] code;
    logic [1:0] id;
    logic       ill;
    logic [7:0] err;
    logic [1:0] err2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rstn, input logic [3:0] valid,
                              input logic [15:0] ops, input logic [3:0] ready,
                              input logic bsy, input logic ov,
                              input logic [3:0] code, input logic [1:0] id,
                              input logic ill, input logic [7:0] err,
                              input logic [1:0] err2);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.ops = ops; v.ready = ready;
    v.bsy = bsy; v.ov = ov; v.code = code; v.id = id; v.ill = ill;
    v.err = err; v.err2 = err2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // accept outputs, then compare the registered outputs after the next edge.
  task automatic applyStimulus(input int row, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n     = v.rstn;
    req_valid = v.valid;
    req_op    = v.ops;
    e.ov = v.ov; e.code = v.code; e.id = v.id; e.ill = v.ill;
    e.err = v.err; e.err2 = v.err2;
    sb.push_back(e);
    #1;
    checkOutput($sformatf("r%0d req_ready", row), 32'(req_ready), 32'(v.ready));
    checkOutput($sformatf("r%0d busy", row), 32'(busy), 32'(v.bsy));
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput($sformatf("r%0d op_valid", row), 32'(op_valid), 32'(got.ov));
    checkOutput($sformatf("r%0d op_code", row), 32'(op_code), 32'(got.code));
    checkOutput($sformatf("r%0d illegal", row), 32'(illegal), 32'(got.ill));
    if (got.ov || got.ill) begin
      checkOutput($sformatf("r%0d op_id", row), 32'(op_id), 32'(got.id));
    end
    checkOutput($sformatf("r%0d err_cnt", row), 32'(err_cnt), 32'(got.err));
    checkOutput($sformatf("r%0d err_cnt_sat", row), 32'(s_err), 32'(got.err2));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;

    // Round-robin fairness: all four hold WRITE_A
    tbl.push_back(mk(1, 4'hF, 16'h1111, 4'b0001, 0, 1, WRITE_A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h1111, 4'b0010, 0, 1, WRITE_A, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h1111, 4'b0100, 0, 1, WRITE_A, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h1111, 4'b1000, 0, 1, WRITE_A, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h1111, 4'b0001, 0, 1, WRITE_A, 0, 0, 0, 0));
    // Sparse / wrap: only req 3, then only req 0 (twice, second needs wrap)
    tbl.push_back(mk(1, 4'h8, 16'h1000, 4'b1000, 0, 1, WRITE_A, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 16'h0001, 4'b0001, 0, 1, WRITE_A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 16'h0001, 4'b0001, 0, 1, WRITE_A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 16'h0000, 4'b0000, 0, 0, OP_NOP,  0, 0, 0, 0));
    // Illegal filtering: req 1 sends 0111 then WRITE_B
    tbl.push_back(mk(1, 4'h2, 16'h0070, 4'b0010, 0, 0, OP_NOP,  1, 1, 1, 1));
    tbl.push_back(mk(1, 4'h2, 16'h0020, 4'b0010, 0, 1, WRITE_B, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'h0, 16'h0000, 4'b0000, 0, 0, OP_NOP,  0, 0, 1, 1));
    // READ spacing: req 2 READ_C, req 3 WRITE_B waiting
    tbl.push_back(mk(1, 4'hC, 16'h2B00, 4'b0100, 0, 1, READ_C,  2, 0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 16'h2000, 4'b0000, 1, 0, OP_NOP,  0, 0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 16'h2000, 4'b0000, 1, 0, OP_NOP,  0, 0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 16'h2000, 4'b1000, 0, 1, WRITE_B, 3, 0, 1, 1));
    tbl.push_back(mk(1, 4'h0, 16'h0000, 4'b0000, 0, 0, OP_NOP,  0, 0, 1, 1));
    // Reset, then five illegal ops (second instance saturates at 3)
    tbl.push_back(mk(0, 4'h0, 16'h0000, 4'b0000, 0, 0, OP_NOP,  0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h4F30, 4'b0001, 0, 0, OP_NOP,  0, 1, 1, 1));
    tbl.push_back(mk(1, 4'hF, 16'h4F30, 4'b0010, 0, 0, OP_NOP,  1, 1, 2, 2));
    tbl.push_back(mk(1, 4'hF, 16'h4F30, 4'b0100, 0, 0, OP_NOP,  2, 1, 3, 3));
    tbl.push_back(mk(1, 4'hF, 16'h4F30, 4'b1000, 0, 0, OP_NOP,  3, 1, 4, 3));
    tbl.push_back(mk(1, 4'hF, 16'h4F30, 4'b0001, 0, 0, OP_NOP,  0, 1, 5, 3));
    tbl.push_back(mk(1, 4'h0, 16'h0000, 4'b0000, 0, 0, OP_NOP,  0, 0, 5, 3));
    // Reset mid-HOLD: req 0 READ_C, req 1 WRITE_A pending across the reset
    tbl.push_back(mk(1, 4'h1, 16'h000B, 4'b0001, 0, 1, READ_C,  0, 0, 5, 3));
    tbl.push_back(mk(1, 4'h2, 16'h0010, 4'b0000, 1, 0, OP_NOP,  0, 0, 5, 3));
    tbl.push_back(mk(0, 4'h2, 16'h0010, 4'b0000, 1, 0, OP_NOP,  0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 16'h0010, 4'b0010, 0, 1, WRITE_A, 1, 0, 0, 0));

    // Power-on reset, held for two edges
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset op_valid", 32'(op_valid), 32'd0);
    checkOutput("reset op_code", 32'(op_code), 32'd0);
    checkOutput("reset op_id", 32'(op_id), 32'd0);
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    checkOutput("reset err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(i, tbl[i]);
    end

    // Measured READ_C to next-issue spacing with a bounded wait; the arbiter
    // is in ISSUE (write) with rr_ptr=2 after the last table row.
    @(negedge clk);
    req_valid = 4'b1100;
    req_op    = 16'h2B00;
    @(posedge clk);
    #1;
    checkOutput("gap read op_valid", 32'(op_valid), 32'd1);
    checkOutput("gap read op_code", 32'(op_code), 32'(READ_C));
    checkOutput("gap read op_id", 32'(op_id), 32'd2);
    @(negedge clk);
    req_valid = 4'b1000;
    req_op    = 16'h2000;
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!op_valid && gap < 10);
    checkOutput("gap cycles", 32'(gap), 32'd3);
    checkOutput("gap next op_code", 32'(op_code), 32'(WRITE_B));
    checkOutput("gap next op_id", 32'(op_id), 32'd3);
    @(negedge clk);
    req_valid = '0;
    req_op    = '0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
